// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: controller states,
// requester ids and the alignment helper.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic REQ_SCALAR = 1'b0;
  localparam logic REQ_VECTOR = 1'b1;

  // Word accesses need the two byte-offset bits clear.
  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker, fixed priority or round-robin on ties.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       valid,
  output logic       winner
);

  // Tie goes to requester 0 in fixed mode, otherwise to whoever was not last served.
  always_comb begin
    valid  = |req;
    winner = REQ_SCALAR;
    if (req == 2'b11)
      winner = (FIXED_PRIO != 0) ? REQ_SCALAR : ~rr_last;
    else if (req[1])
      winner = REQ_VECTOR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-word data memory port between the scalar
// pipeline (req0) and the vector unit (req1). Two-state registered controller,
// at most one access per cycle, registered read data with rvalid pulses.
// Optional macro MEM_ARB_ALIGN_CHECK_EN: unaligned accesses are suppressed at
// the memory and answered with rvalid+err and zero data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state_q, state_d;
  logic              lat_id, lat_we, rr_last;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        eligible;
  logic              pick_valid, pick_id;
  logic              in_access, bad_align, do_access;
  logic [1:0]        rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q [2];

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req    (eligible),
    .rr_last(rr_last),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign in_access = (state_q == ST_ACCESS);

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign bad_align = misaligned(lat_addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  assign do_access   = in_access & ~bad_align & ~reset;
  assign mem_read    = do_access & ~lat_we;
  assign mem_write   = do_access & lat_we;
  assign mem_address = lat_addr;
  assign mem_data_in = lat_wdata;
  assign gnt0        = in_access & (lat_id == REQ_SCALAR);
  assign gnt1        = in_access & (lat_id == REQ_VECTOR);
  assign rvalid0     = rvalid_q[0];
  assign rvalid1     = rvalid_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign rdata0      = rdata_q[0];
  assign rdata1      = rdata_q[1];

  // Next state: the granted requester is masked during its own access, so the
  // same pick rule covers both the IDLE start and the back-to-back handover.
  always_comb begin
    eligible = {req1, req0};
    if (in_access)
      eligible[lat_id] = 1'b0;
    state_d = pick_valid ? ST_ACCESS : ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Latch the winning request and remember who was served for round-robin.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_id    <= REQ_SCALAR;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rr_last   <= REQ_VECTOR;
    end else if (pick_valid) begin
      lat_id    <= pick_id;
      lat_we    <= pick_id ? we1 : we0;
      lat_addr  <= pick_id ? addr1 : addr0;
      lat_wdata <= pick_id ? wdata1 : wdata0;
      rr_last   <= pick_id;
    end
  end

  // Response registers: capture read data (or an alignment error) at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      if (in_access) begin
        if (bad_align) begin
          rvalid_q[lat_id] <= 1'b1;
          err_q[lat_id]    <= 1'b1;
          rdata_q[lat_id]  <= '0;
        end else if (!lat_we) begin
          rvalid_q[lat_id] <= 1'b1;
          rdata_q[lat_id]  <= mem_data_out;
        end
      end
    end
  end

endmodule
